// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the toggle-handshake destination controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cdc_hs_pkg;

   // Controller states; INIT covers the window where the unreset synchronizer flops settle
   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CAPT   = 3'd3,
      ST_HOLD   = 3'd4,
      ST_ACK    = 3'd5
   } state_t;

   // Shared width of the INIT and SETTLE counters (both saturate, never wrap)
   localparam int CNT_W = 4;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 10;
   localparam int SETTLE_CYC_MIN  = 0;
   localparam int SETTLE_CYC_MAX  = 7;

   function automatic bit sync_stages_ok(input int n);
      return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
   endfunction

   function automatic bit settle_cyc_ok(input int n);
      return (n >= SETTLE_CYC_MIN) && (n <= SETTLE_CYC_MAX);
   endfunction

endpackage

// File: rtl/cdc_hs_dest_ctrl_sync.sv
// Single-bit multi-flop synchronizer (sync_cdc_bit) bringing an async level into clk.
// Latency: C_SYNC_STAGES clk edges from input change to q.
// Backpressure: none; free-running, flops carry no reset by design.
module sync_cdc_bit #(
   parameter int C_SYNC_STAGES = 3
) (
   input  logic clk,
   input  logic d,
   output logic q
);

   logic [C_SYNC_STAGES-1:0] sync_q;

   // Shift the async level through the synchronizer chain
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[C_SYNC_STAGES-2:0], d};
   end

   assign q = sync_q[C_SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_dest_ctrl.sv
// Destination side of a 2-phase req/ack toggle handshake; lands a source-held word on a valid/ready stream.
// Latency: src_req edge to m_valid = C_SYNC_STAGES + C_SETTLE_CYC + 2 clk; accept to dst_ack toggle = 2 clk.
// Backpressure: one word in flight, m_valid/m_data held until m_ready; ack withheld so the source stalls.
// Optional: define CDC_HS_OVR_CHECK_EN to build the sticky overrun detector driving ovr_err.
module cdc_hs_dest_ctrl
   import cdc_hs_pkg::*;
#(
   parameter int C_DATA_WIDTH  = 32,
   parameter int C_SYNC_STAGES = 3,
   parameter int C_SETTLE_CYC  = 1
) (
   input  logic                    clk,
   input  logic                    arstn,
   input  logic                    src_req,
   input  logic [C_DATA_WIDTH-1:0] src_data,
   output logic                    dst_ack,
   output logic                    m_valid,
   output logic [C_DATA_WIDTH-1:0] m_data,
   input  logic                    m_ready,
   output logic                    busy,
   output logic                    ovr_err
);

   if (!sync_stages_ok(C_SYNC_STAGES)) begin : g_bad_sync_stages
      $error("cdc_hs_dest_ctrl: C_SYNC_STAGES must be within 2..10");
   end
   if (!settle_cyc_ok(C_SETTLE_CYC)) begin : g_bad_settle_cyc
      $error("cdc_hs_dest_ctrl: C_SETTLE_CYC must be within 0..7");
   end

   // INIT exits on its (C_SYNC_STAGES+1)-th cycle; SETTLE exits on its C_SETTLE_CYC-th cycle
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(C_SYNC_STAGES);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(C_SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             req_s;
   logic             req_prev;
   logic             pend;

   sync_cdc_bit #(
      .C_SYNC_STAGES (C_SYNC_STAGES)
   ) u_req_sync (
      .clk (clk),
      .d   (src_req),
      .q   (req_s)
   );

   // A pending request is any level difference from the last consumed req level
   assign pend    = req_s ^ req_prev;
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   // Handshake FSM with registered dst_ack, stream outputs and busy
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state    <= ST_INIT;
         cnt      <= '0;
         req_prev <= 1'b0;
         dst_ack  <= 1'b0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         busy     <= 1'b1;
      end else begin
         case (state)
            ST_INIT: begin
               // Synchronizer content is unknown after reset: adopt its level, never a word
               if (cnt == INIT_LAST) begin
                  req_prev <= req_s;
                  cnt      <= '0;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_IDLE: begin
               if (pend) begin
                  busy  <= 1'b1;
                  cnt   <= '0;
                  state <= (C_SETTLE_CYC == 0) ? ST_CAPT : ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt   <= '0;
                  state <= ST_CAPT;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_CAPT: begin
               // Source bus is stable by now; req_prev is only resynchronized here
               m_data   <= src_data;
               m_valid  <= 1'b1;
               req_prev <= req_s;
               state    <= ST_HOLD;
            end
            ST_HOLD: begin
               if (m_valid && m_ready) begin
                  m_valid <= 1'b0;
                  state   <= ST_ACK;
               end
            end
            ST_ACK: begin
               dst_ack <= ~dst_ack;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               cnt   <= '0;
               busy  <= 1'b1;
               state <= ST_INIT;
            end
         endcase
      end
   end

`ifdef CDC_HS_OVR_CHECK_EN
   logic ovr_hit;
   logic ovr_q;

   // Before CAPT the accepted level is ~req_prev; from HOLD on it is req_prev itself
   always_comb begin
      ovr_hit = 1'b0;
      case (state)
         ST_SETTLE, ST_CAPT: ovr_hit = (req_s == req_prev);
         ST_HOLD, ST_ACK:    ovr_hit = (req_s != req_prev);
         default:            ovr_hit = 1'b0;
      endcase
   end

   // Sticky overrun flag, cleared only by reset
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         ovr_q <= 1'b0;
      end else if (ovr_hit) begin
         ovr_q <= 1'b1;
      end
   end

   assign ovr_err = ovr_q;
`else
   assign ovr_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_dest_ctrl.sv
// Directed self-checking bench for cdc_hs_dest_ctrl (32-bit word, 3 sync stages, 1 settle cycle).
// Latency: expected req-to-valid = SYNC + SETTLE + 2, accept-to-ack = 2.
// Backpressure: exercised by holding m_ready low while a word is presented.
module tb_cdc_hs_dest_ctrl;

   localparam int DW     = 32;
   localparam int SYNC   = 3;
   localparam int SETTLE = 1;
`ifdef CDC_HS_OVR_CHECK_EN
   localparam logic EXP_OVR = 1'b1;
`else
   localparam logic EXP_OVR = 1'b0;
`endif

   logic          clk;
   logic          arstn;
   logic          src_req;
   logic [DW-1:0] src_data;
   logic          dst_ack;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic          busy;
   logic          ovr_err;

   int   n_checks;
   int   n_fail;
   logic exp_ack;

   cdc_hs_dest_ctrl #(
      .C_DATA_WIDTH  (DW),
      .C_SYNC_STAGES (SYNC),
      .C_SETTLE_CYC  (SETTLE)
   ) dut (
      .clk      (clk),
      .arstn    (arstn),
      .src_req  (src_req),
      .src_data (src_data),
      .dst_ack  (dst_ack),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_ready  (m_ready),
      .busy     (busy),
      .ovr_err  (ovr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Counts posedges (sampled #1 after) until m_valid is high; returns 99 on timeout
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (cyc < 60 && m_valid !== 1'b1) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (m_valid !== 1'b1) cyc = 99;
   endtask

   task automatic test_reset;
      int  cyc;
      int  seen;
      arstn = 1'b0; src_req = 1'b1; src_data = '0; m_ready = 1'b1;
      exp_ack = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
      n_checks++; if (dst_ack !== 1'b0) begin n_fail++; $display("FAIL reset_dst_ack got %b want 0", dst_ack); end
      n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data); end
      n_checks++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovr_err got %b want 0", ovr_err); end
      @(negedge clk); arstn = 1'b1;
      cyc = 0;
      while (cyc < 30 && busy !== 1'b0) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_checks++; if (cyc != SYNC + 1) begin n_fail++; $display("FAIL init_exit_cycles got %0d want %0d", cyc, SYNC + 1); end
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (m_valid !== 1'b0) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL init_no_word got %0d beats want 0", seen); end
      n_checks++; if (dst_ack !== 1'b0) begin n_fail++; $display("FAIL init_dst_ack got %b want 0", dst_ack); end
   endtask

   task automatic test_basic;
      int cyc;
      @(negedge clk);
      m_ready = 1'b1; src_data = 32'hDEADBEEF; src_req = ~src_req;
      wait_valid(cyc);
      n_checks++; if (cyc != SYNC + SETTLE + 2) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", cyc, SYNC + SETTLE + 2); end
      n_checks++; if (m_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_data got %h want deadbeef", m_data); end
      @(posedge clk); #1;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_beat got m_valid=%b want 0", m_valid); end
      exp_ack = ~exp_ack;
      cyc = 1;
      while (cyc < 20 && dst_ack !== exp_ack) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL basic_ack_latency got %0d want 2", cyc); end
      n_checks++; if (dst_ack !== exp_ack) begin n_fail++; $display("FAIL basic_ack_value got %b want %b", dst_ack, exp_ack); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle got %b want 0", busy); end
   endtask

   task automatic test_stall;
      int cyc;
      @(negedge clk);
      m_ready = 1'b0; src_data = 32'hCAFEF00D; src_req = ~src_req;
      wait_valid(cyc);
      n_checks++; if (cyc == 99) begin n_fail++; $display("FAIL stall_valid_timeout got none want m_valid"); end
      repeat (20) begin
         @(posedge clk); #1;
         n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_held got %b want 1", m_valid); end
         n_checks++; if (m_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL stall_data_held got %h want cafef00d", m_data); end
         n_checks++; if (dst_ack !== exp_ack) begin n_fail++; $display("FAIL stall_ack_held got %b want %b", dst_ack, exp_ack); end
      end
      @(negedge clk); m_ready = 1'b1;
      exp_ack = ~exp_ack;
      cyc = 0;
      while (cyc < 20 && dst_ack !== exp_ack) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL stall_ack_latency got %0d want 2", cyc); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop got %b want 0", m_valid); end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] got[$];
      int   sent;
      int   acks;
      logic last_ack;
      m_ready = 1'b1;
      @(negedge clk);
      last_ack = dst_ack;
      sent = 1; acks = 0;
      src_data = 32'h1; src_req = ~src_req;
      repeat (150) begin
         @(negedge clk);
         if (m_valid === 1'b1 && m_ready === 1'b1) got.push_back(m_data);
         if (dst_ack !== last_ack) begin
            last_ack = dst_ack;
            acks++;
            exp_ack = ~exp_ack;
            if (sent < 4) begin
               sent++;
               src_data = DW'(sent);
               src_req = ~src_req;
            end
         end
      end
      n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL b2b_beat_count got %0d want 4", got.size()); end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         n_checks++; if (got[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL b2b_order beat %0d got %h want %h", i, got[i], DW'(i + 1)); end
      end
      n_checks++; if (acks != 4) begin n_fail++; $display("FAIL b2b_ack_count got %0d want 4", acks); end
      n_checks++; if (dst_ack !== exp_ack) begin n_fail++; $display("FAIL b2b_ack_level got %b want %b", dst_ack, exp_ack); end
   endtask

   task automatic test_overrun;
      int cyc;
      int beats;
      @(negedge clk);
      m_ready = 1'b0; src_data = 32'h55AA55AA; src_req = ~src_req;
      wait_valid(cyc);
      n_checks++; if (cyc == 99) begin n_fail++; $display("FAIL ovr_valid_timeout got none want m_valid"); end
      @(negedge clk); src_req = ~src_req;
      repeat (6) @(negedge clk);
      src_req = ~src_req;
      repeat (8) @(negedge clk);
      n_checks++; if (ovr_err !== EXP_OVR) begin n_fail++; $display("FAIL ovr_flag got %b want %b", ovr_err, EXP_OVR); end
      n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h55AA55AA) begin n_fail++; $display("FAIL ovr_word_held got v=%b d=%h want v=1 d=55aa55aa", m_valid, m_data); end
      m_ready = 1'b1;
      beats = 0;
      repeat (30) begin
         if (m_valid === 1'b1 && m_ready === 1'b1) beats++;
         @(negedge clk);
      end
      exp_ack = ~exp_ack;
      n_checks++; if (beats != 1) begin n_fail++; $display("FAIL ovr_single_beat got %0d want 1", beats); end
      n_checks++; if (dst_ack !== exp_ack) begin n_fail++; $display("FAIL ovr_ack got %b want %b", dst_ack, exp_ack); end
      n_checks++; if (ovr_err !== EXP_OVR) begin n_fail++; $display("FAIL ovr_sticky got %b want %b", ovr_err, EXP_OVR); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_in_hold;
      int cyc;
      int seen;
      @(negedge clk);
      m_ready = 1'b0; src_data = 32'h12345678; src_req = ~src_req;
      wait_valid(cyc);
      n_checks++; if (cyc == 99) begin n_fail++; $display("FAIL rih_valid_timeout got none want m_valid"); end
      @(negedge clk);
      arstn = 1'b0; src_req = 1'b0;
      exp_ack = 1'b0;
      #1;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rih_m_valid got %b want 0", m_valid); end
      n_checks++; if (dst_ack !== 1'b0) begin n_fail++; $display("FAIL rih_dst_ack got %b want 0", dst_ack); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rih_busy got %b want 1", busy); end
      n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL rih_m_data got %h want 0", m_data); end
      n_checks++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL rih_ovr_err got %b want 0", ovr_err); end
      repeat (3) @(negedge clk);
      arstn = 1'b1; m_ready = 1'b1;
      cyc = 0; seen = 0;
      while (cyc < 30 && busy !== 1'b0) begin
         @(posedge clk); #1;
         cyc++;
         if (m_valid !== 1'b0) seen++;
      end
      n_checks++; if (cyc != SYNC + 1) begin n_fail++; $display("FAIL rih_init_cycles got %0d want %0d", cyc, SYNC + 1); end
      repeat (20) begin
         @(posedge clk); #1;
         if (m_valid !== 1'b0) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rih_stale_beat got %0d beats want 0", seen); end
      n_checks++; if (dst_ack !== 1'b0) begin n_fail++; $display("FAIL rih_ack_after got %b want 0", dst_ack); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      arstn    = 1'b0;
      src_req  = 1'b0;
      src_data = '0;
      m_ready  = 1'b0;
      exp_ack  = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_overrun();
      test_reset_in_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
